// File: rtl/mux_2_1_pkg.sv
// Shared CPU datapath package.
// Purpose: single home for the gate-level timing convention used by every
//          gate-level datapath block (time unit 1ps, precision 1ps) and the
//          default per-gate propagation delay.
// Ports:   none (package).
`timescale 1ps/1ps

package mux_2_1_pkg;

    // Default propagation delay of one primitive gate, in ps.
    localparam int GATE_DELAY_PS = 50;

    // Gates on the select-to-output path of one 2:1 stage (NOT, AND, OR).
    localparam int MUX_SEL_GATES = 3;

    // Worst-case settle time of an N-level 2:1 mux tree.
    function automatic int mux_tree_delay_ps(input int levels, input int gate_delay);
        return levels * MUX_SEL_GATES * gate_delay;
    endfunction

endpackage

// File: rtl/mux_2_1_bit.sv
// Single-lane 2:1 gate cell.
// Purpose: one output bit built from two delayed ANDs and one delayed OR.
//          The inverted select is supplied from outside so one inverter
//          serves every lane.
// Ports:
//   i_i0   - data taken when select is 0
//   i_i1   - data taken when select is 1
//   i_sel  - lane select
//   i_nsel - inverted lane select (shared)
//   o_out  - selected bit, 2 gate delays after data, 3 after select
`timescale 1ps/1ps

module mux_2_1_bit
    import mux_2_1_pkg::*;
#(
    parameter int GATE_DELAY = GATE_DELAY_PS
) (
    input  logic i_i0,
    input  logic i_i1,
    input  logic i_sel,
    input  logic i_nsel,
    output logic o_out
);

    wire w_and0;
    wire w_and1;
    wire w_or;

    and #(GATE_DELAY) u_and0 (w_and0, i_i0, i_nsel);
    and #(GATE_DELAY) u_and1 (w_and1, i_i1, i_sel);
    or  #(GATE_DELAY) u_or   (w_or,   w_and0, w_and1);

    assign o_out = w_or;

endmodule

// File: rtl/mux_2_1.sv
// Gate-level 2:1 selector with registered tap.
// Purpose: leaf primitive of the datapath mux trees. The combinational path
//          is made of explicit delayed gates so tree timing is visible in
//          simulation; out_q is a plain D flop copy of out.
// Ports:
//   clk   - clock, out_q updates on rising edge
//   reset - asynchronous active-high clear of out_q
//   i0    - WIDTH-bit data selected when sel = 0
//   i1    - WIDTH-bit data selected when sel = 1
//   sel   - select shared by all lanes
//   out   - combinational selected data
//   out_q - out registered on clk
`timescale 1ps/1ps

module mux_2_1
    import mux_2_1_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int GATE_DELAY = GATE_DELAY_PS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    wire             w_nsel;
    wire [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] r_out_q;

    // One inverter drives every lane, so sel fans out once and the
    // select path is the same three gates for every bit.
    not #(GATE_DELAY) u_inv_sel (w_nsel, sel);

    for (genvar b = 0; b < WIDTH; b++) begin : g_lane
        mux_2_1_bit #(
            .GATE_DELAY (GATE_DELAY)
        ) u_bit (
            .i_i0   (i0[b]),
            .i_i1   (i1[b]),
            .i_sel  (sel),
            .i_nsel (w_nsel),
            .o_out  (w_out[b])
        );
    end

    assign out = w_out;

    // Registered tap carries no gate delay; reset clears it at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_q <= '0;
        end else begin
            r_out_q <= w_out;
        end
    end

    assign out_q = r_out_q;

endmodule

// File: tb/tb_mux_2_1.sv
`timescale 1ps/1ps

module tb_mux_2_1;

    int n_checks = 0;
    int n_errors = 0;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #500 clk = ~clk;

    // WIDTH=1 instance for exhaustive and delay checks
    logic a_i0 = 1'b0, a_i1 = 1'b0, a_sel = 1'b0;
    logic a_out, a_q;

    // WIDTH=4 instance for registered path and random checks
    logic [3:0] r_i0 = '0, r_i1 = '0;
    logic       r_sel = 1'b0;
    logic [3:0] w_out4, w_q4;

    // 4:1 tree from three WIDTH=1 instances
    logic [3:0] t_i = '0;
    logic [1:0] t_sel = '0;
    logic       t_m0, t_m1, t_out, t_q0, t_q1, t_q2;

    mux_2_1 #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .i0(a_i0), .i1(a_i1), .sel(a_sel),
        .out(a_out), .out_q(a_q)
    );

    mux_2_1 #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .i0(r_i0), .i1(r_i1), .sel(r_sel),
        .out(w_out4), .out_q(w_q4)
    );

    mux_2_1 #(.WIDTH(1)) tree_lo (
        .clk(clk), .reset(reset), .i0(t_i[0]), .i1(t_i[1]), .sel(t_sel[0]),
        .out(t_m0), .out_q(t_q0)
    );

    mux_2_1 #(.WIDTH(1)) tree_hi (
        .clk(clk), .reset(reset), .i0(t_i[2]), .i1(t_i[3]), .sel(t_sel[0]),
        .out(t_m1), .out_q(t_q1)
    );

    mux_2_1 #(.WIDTH(1)) tree_top (
        .clk(clk), .reset(reset), .i0(t_m0), .i1(t_m1), .sel(t_sel[1]),
        .out(t_out), .out_q(t_q2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t ps", name, act, exp, $time);
        end
    endtask

    // Reference: each lane takes i1 when sel is 1, else i0, computed lane by lane.
    function automatic logic [3:0] sel_model(input logic [3:0] d0, input logic [3:0] d1, input logic s);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = s ? d1[k] : d0[k];
        return r;
    endfunction

    // Registered-path expectation captured at each rising edge.
    bit         chk_en = 1'b0;
    bit         exp_q_valid = 1'b0;
    logic [3:0] exp_q = '0;

    always @(posedge clk) begin
        exp_q       = reset ? 4'h0 : sel_model(r_i0, r_i1, r_sel);
        exp_q_valid = chk_en;
    end

    // Compare process: inputs change 100ps after the rising edge, so both
    // outputs are settled by the falling edge.
    always @(negedge clk) begin
        if (chk_en && exp_q_valid) begin
            check("rand_out", {28'd0, w_out4}, {28'd0, sel_model(r_i0, r_i1, r_sel)});
            check("rand_out_q", {28'd0, w_q4}, {28'd0, (reset ? 4'h0 : exp_q)});
        end
    end

    logic       exh_tab [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] reg_tab [4] = '{4'hA, 4'h5, 4'hA, 4'h5};

    initial begin
        logic [2:0] v3;
        logic [5:0] v6;

        // reset state
        #10 reset = 1'b1;
        #10 check("reset_q", {28'd0, w_q4}, 32'h0);
        @(posedge clk);
        #10 check("reset_hold_q", {28'd0, w_q4}, 32'h0);
        #100 reset = 1'b0;

        // exhaustive WIDTH=1
        for (int k = 0; k < 8; k++) begin
            v3 = 3'(k);
            {a_sel, a_i1, a_i0} = v3;
            #200;
            check($sformatf("exh_%0d", k), {31'd0, a_out}, {31'd0, exh_tab[k]});
        end

        // select path delay: 150ps
        a_i0 = 1'b1; a_i1 = 1'b0; a_sel = 1'b0;
        #200;
        a_sel = 1'b1;
        #149 check("sel_delay_before", {31'd0, a_out}, 32'd1);
        #2   check("sel_delay_after", {31'd0, a_out}, 32'd0);

        // data path delay: 100ps
        #200;
        a_sel = 1'b0; a_i0 = 1'b0; a_i1 = 1'b0;
        #200;
        a_i0 = 1'b1;
        #99 check("data_delay_before", {31'd0, a_out}, 32'd0);
        #2  check("data_delay_after", {31'd0, a_out}, 32'd1);

        @(posedge clk);
        #10 check("w1_out_q", {31'd0, a_q}, 32'd1);

        // registered path, sel toggling from 0
        @(posedge clk);
        #100;
        r_i0 = 4'hA; r_i1 = 4'h5;
        for (int n = 0; n < 4; n++) begin
            r_sel = n[0];
            @(posedge clk);
            #400 check($sformatf("reg_q_%0d", n), {28'd0, w_q4}, {28'd0, reg_tab[n]});
        end

        // reset mid-cycle with out_q = 5
        reset = 1'b1;
        #1 check("rst_immediate", {28'd0, w_q4}, 32'h0);
        @(posedge clk);
        #400 check("rst_hold_1", {28'd0, w_q4}, 32'h0);
        @(posedge clk);
        #400 check("rst_hold_2", {28'd0, w_q4}, 32'h0);
        r_sel = 1'b0;
        reset = 1'b0;
        #1 check("rst_release_no_edge", {28'd0, w_q4}, 32'h0);
        @(posedge clk);
        #400 check("rst_release_load", {28'd0, w_q4}, 32'hA);

        // 4:1 tree sweep
        for (int k = 0; k < 64; k++) begin
            v6 = 6'(k);
            {t_sel, t_i} = v6;
            #301 check($sformatf("tree_%0d", k), {31'd0, t_out}, {31'd0, t_i[t_sel]});
            #49;
        end
        @(posedge clk);
        @(posedge clk);
        #10;
        check("tree_q_lo", {31'd0, t_q0}, {31'd0, t_i[{1'b0, t_sel[0]}]});
        check("tree_q_hi", {31'd0, t_q1}, {31'd0, t_i[{1'b1, t_sel[0]}]});
        check("tree_q_top", {31'd0, t_q2}, {31'd0, t_i[t_sel]});

        // randomized phase with occasional reset pulses
        @(posedge clk);
        #100;
        r_i0 = 4'($urandom); r_i1 = 4'($urandom); r_sel = 1'($urandom);
        chk_en = 1'b1;
        repeat (300) begin
            @(posedge clk);
            #100;
            r_i0  = 4'($urandom);
            r_i1  = 4'($urandom);
            r_sel = 1'($urandom);
            reset = ($urandom_range(0, 9) == 0);
        end
        @(posedge clk);
        #100;
        chk_en = 1'b0;
        reset  = 1'b0;

        #1000;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
